// File: rtl/full_adder_core.sv
// ---------------------------------------------------------------------------
// full_adder_core: registered WIDTH-bit ripple-carry full adder.
// Optional ovf port via FULL_ADDER_OVF_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef FULL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    logic w_p;
    assign w_p          = a[i] ^ b[i];
    assign w_sum[i]     = w_p ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & w_p);
  end

  // Data registers hold while in_valid is low, so idle operand values never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  logic w_ovf;
  logic r_ovf;

  assign w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_full_adder_core.sv
// ---------------------------------------------------------------------------
// tb_full_adder_core: directed and random checks of full_adder_core at
// WIDTH=1, 8 and 16 sharing one clock and reset.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_full_adder_core;

  logic clk;
  logic rst_n;

  logic       w1_v, w1_a, w1_b, w1_cin, w1_sum, w1_cout, w1_ov;
  logic       w8_v, w8_cin, w8_cout, w8_ov;
  logic [7:0] w8_a, w8_b, w8_sum;
  logic        w16_v, w16_cin, w16_cout, w16_ov;
  logic [15:0] w16_a, w16_b, w16_sum;
`ifdef FULL_ADDER_OVF_EN
  logic w1_ovf, w8_ovf, w16_ovf;
`endif

  int errors = 0;
  int checks = 0;

  full_adder_core #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w1_v), .a(w1_a), .b(w1_b), .cin(w1_cin),
    .sum(w1_sum), .cout(w1_cout),
`ifdef FULL_ADDER_OVF_EN
    .ovf(w1_ovf),
`endif
    .out_valid(w1_ov)
  );

  full_adder_core #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(w8_v), .a(w8_a), .b(w8_b), .cin(w8_cin),
    .sum(w8_sum), .cout(w8_cout),
`ifdef FULL_ADDER_OVF_EN
    .ovf(w8_ovf),
`endif
    .out_valid(w8_ov)
  );

  full_adder_core #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(w16_v), .a(w16_a), .b(w16_b), .cin(w16_cin),
    .sum(w16_sum), .cout(w16_cout),
`ifdef FULL_ADDER_OVF_EN
    .ovf(w16_ovf),
`endif
    .out_valid(w16_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {sum,cout} for {a,b,cin} = 000..111
  logic [1:0] c_w1_exp [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  logic [16:0] tot;
  logic [15:0] exp_sum;
  logic        exp_cout;
  logic        exp_ov;

  initial begin
    rst_n = 1'b0;
    w1_v = 0; w1_a = 0; w1_b = 0; w1_cin = 0;
    w8_v = 0; w8_a = 0; w8_b = 0; w8_cin = 0;
    w16_v = 0; w16_a = 0; w16_b = 0; w16_cin = 0;
    #2;
    check("reset_w8_sum", 64'(w8_sum), 64'h0);
    check("reset_w8_cout", 64'(w8_cout), 64'h0);
    check("reset_w8_valid", 64'(w8_ov), 64'h0);
    check("reset_w1_valid", 64'(w1_ov), 64'h0);
    #10;
    rst_n = 1'b1;

    // WIDTH=1 exhaustive, back-to-back
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      w1_v = 1'b1; w1_a = v[2]; w1_b = v[1]; w1_cin = v[0];
      tick();
      check($sformatf("w1_sumcout_%0d", i), 64'({w1_sum, w1_cout}), 64'(c_w1_exp[i]));
      check($sformatf("w1_valid_%0d", i), 64'(w1_ov), 64'h1);
    end
    w1_v = 1'b0;

    // WIDTH=8 carry boundaries
    w8_v = 1; w8_a = 8'hFF; w8_b = 8'h01; w8_cin = 0;
    tick();
    check("w8_ff_01_sum", 64'(w8_sum), 64'h00);
    check("w8_ff_01_cout", 64'(w8_cout), 64'h1);
    w8_a = 8'hFF; w8_b = 8'hFF; w8_cin = 1;
    tick();
    check("w8_ff_ff_sum", 64'(w8_sum), 64'hFF);
    check("w8_ff_ff_cout", 64'(w8_cout), 64'h1);
    check("w8_b2b_valid", 64'(w8_ov), 64'h1);

`ifdef FULL_ADDER_OVF_EN
    w8_a = 8'h7F; w8_b = 8'h01; w8_cin = 0;
    tick();
    check("ovf_7f_01", 64'(w8_ovf), 64'h1);
    check("ovf_7f_01_sum", 64'(w8_sum), 64'h80);
    w8_a = 8'h80; w8_b = 8'h80; w8_cin = 0;
    tick();
    check("ovf_80_80", 64'(w8_ovf), 64'h1);
    check("ovf_80_80_cout", 64'(w8_cout), 64'h1);
    check("ovf_80_80_sum", 64'(w8_sum), 64'h00);
    w8_a = 8'h01; w8_b = 8'h01; w8_cin = 0;
    tick();
    check("ovf_01_01", 64'(w8_ovf), 64'h0);
`endif

    // Hold
    w8_a = 8'd3; w8_b = 8'd4; w8_cin = 1;
    tick();
    check("hold_cap_sum", 64'(w8_sum), 64'h08);
    w8_v = 0; w8_a = 8'hAA; w8_b = 8'h55; w8_cin = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_sum_%0d", i), 64'(w8_sum), 64'h08);
      check($sformatf("hold_cout_%0d", i), 64'(w8_cout), 64'h0);
      check($sformatf("hold_valid_%0d", i), 64'(w8_ov), 64'h0);
    end

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_sum", 64'(w8_sum), 64'h0);
    check("areset_cout", 64'(w8_cout), 64'h0);
    check("areset_valid", 64'(w8_ov), 64'h0);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_sum", 64'(w8_sum), 64'h0);
    check("post_rst_valid", 64'(w8_ov), 64'h0);

    // Capture held off while in reset
    w8_v = 1; w8_a = 8'h11; w8_b = 8'h22; w8_cin = 0;
    rst_n = 1'b0;
    tick();
    check("rst_nocap_sum", 64'(w8_sum), 64'h0);
    check("rst_nocap_valid", 64'(w8_ov), 64'h0);
    rst_n = 1'b1;
    tick();
    check("first_cap_sum", 64'(w8_sum), 64'h33);
    check("first_cap_valid", 64'(w8_ov), 64'h1);
    w8_v = 0;

    // WIDTH=16 random cross-check
    exp_sum = '0; exp_cout = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      w16_a = 16'($urandom); w16_b = 16'($urandom);
      w16_cin = 1'($urandom_range(0, 1)); w16_v = 1'($urandom_range(0, 1));
      if (w16_v) begin
        tot = {1'b0, w16_a} + {1'b0, w16_b} + 17'(w16_cin);
        exp_sum = tot[15:0];
        exp_cout = tot[16];
      end
      exp_ov = w16_v;
      tick();
      check("rnd_sum", 64'(w16_sum), 64'(exp_sum));
      check("rnd_cout", 64'(w16_cout), 64'(exp_cout));
      check("rnd_valid", 64'(w16_ov), 64'(exp_ov));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
